// File: rtl/axi_mm_slave_pkg.sv
// Field layouts for the AIB link words carried by the AXI-MM slave-end packer.
// Each struct is ordered MSB-first, so it lines up bit-exactly with its link word.
package axi_mm_slave_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;
    localparam int BRST_W = 2;
    localparam int RESP_W = 2;

    localparam int AR_WORD_W = ADDR_W + BRST_W + LEN_W + SIZE_W + ID_W;  // 49
    localparam int W_WORD_W  = 1 + STRB_W + DATA_W + ID_W;               // 77
    localparam int R_WORD_W  = RESP_W + 1 + DATA_W + ID_W;               // 71
    localparam int B_WORD_W  = RESP_W + ID_W;                            // 6
    localparam int R_LAST_BIT = DATA_W + ID_W;                           // 68

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BRST_W-1:0] burst;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
        logic [ID_W-1:0]   id;
    } ar_word_t;

    typedef struct packed {
        logic              last;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
    } w_word_t;

    typedef struct packed {
        logic [RESP_W-1:0] resp;
        logic              last;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
    } r_word_t;

    typedef struct packed {
        logic [RESP_W-1:0] resp;
        logic [ID_W-1:0]   id;
    } b_word_t;

endpackage

// File: rtl/axi_mm_skid_buf.sv
// Two-entry skid buffer: registered valid/data out, registered ready in.
// Entry0 always feeds the output; entry1 only catches a beat during a stall.
module axi_mm_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             v0_q, v0_d, v1_q, v1_d;
    logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic             push, pop;

    assign in_ready  = !v1_q;
    assign out_valid = v0_q;
    assign out_data  = d0_q;
    assign push      = in_valid && !v1_q;
    assign pop       = v0_q && out_ready;

    always_comb begin
        v0_d = v0_q;
        v1_d = v1_q;
        d0_d = d0_q;
        d1_d = d1_q;
        if (pop) begin
            // push cannot coincide with a held entry1, so these cases are exclusive
            if (v1_q) begin
                d0_d = d1_q;
                v1_d = 1'b0;
            end else if (push) begin
                d0_d = in_data;
            end else begin
                v0_d = 1'b0;
            end
        end else if (push) begin
            if (!v0_q) begin
                d0_d = in_data;
                v0_d = 1'b1;
            end else begin
                d1_d = in_data;
                v1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            d0_q <= '0;
            d1_q <= '0;
        end else begin
            v0_q <= v0_d;
            v1_q <= v1_d;
            d0_q <= d0_d;
            d1_q <= d1_d;
        end
    end

endmodule

// File: rtl/axi_mm_slave_name.sv
// Slave end of the AIB AXI-MM link: unpacks AR/AW/W words onto an AXI4 manager port
// and packs R/B back to TX words. Optional AXI_MM_SLAVE_PROTOCOL_CHECK_EN adds err_sticky.
module axi_mm_slave_name
    import axi_mm_slave_pkg::*;
#(
    parameter int MAX_RD_OUTSTANDING = 16,
    parameter int MAX_WR_OUTSTANDING = 16
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr_n,
    input  logic                 user_ar_vld,
    input  logic [AR_WORD_W-1:0] rxfifo_ar_data,
    output logic                 user_ar_ready,
    input  logic                 user_aw_vld,
    input  logic [AR_WORD_W-1:0] rxfifo_aw_data,
    output logic                 user_aw_ready,
    input  logic                 user_w_vld,
    input  logic [W_WORD_W-1:0]  rxfifo_w_data,
    output logic                 user_w_ready,
    output logic                 user_r_vld,
    output logic [R_WORD_W-1:0]  txfifo_r_data,
    input  logic                 user_r_ready,
    output logic                 user_b_vld,
    output logic [B_WORD_W-1:0]  txfifo_b_data,
    input  logic                 user_b_ready,
    output logic [3:0]           user_arid,
    output logic [2:0]           user_arsize,
    output logic [7:0]           user_arlen,
    output logic [1:0]           user_arburst,
    output logic [31:0]          user_araddr,
    output logic                 user_arvalid,
    input  logic                 user_arready,
    output logic [3:0]           user_awid,
    output logic [2:0]           user_awsize,
    output logic [7:0]           user_awlen,
    output logic [1:0]           user_awburst,
    output logic [31:0]          user_awaddr,
    output logic                 user_awvalid,
    input  logic                 user_awready,
    output logic [3:0]           user_wid,
    output logic [63:0]          user_wdata,
    output logic [7:0]           user_wstrb,
    output logic                 user_wlast,
    output logic                 user_wvalid,
    input  logic                 user_wready,
    input  logic [3:0]           user_rid,
    input  logic [63:0]          user_rdata,
    input  logic                 user_rlast,
    input  logic [1:0]           user_rresp,
    input  logic                 user_rvalid,
    output logic                 user_rready,
    input  logic [3:0]           user_bid,
    input  logic [1:0]           user_bresp,
    input  logic                 user_bvalid,
    output logic                 user_bready,
    output logic [7:0]           rd_outstanding,
    output logic [7:0]           wr_outstanding,
    input  logic                 m_gen2_mode
`ifdef AXI_MM_SLAVE_PROTOCOL_CHECK_EN
    ,
    output logic [1:0]           err_sticky
`endif
);

    localparam logic [7:0] RD_MAX = 8'(MAX_RD_OUTSTANDING);
    localparam logic [7:0] WR_MAX = 8'(MAX_WR_OUTSTANDING);

    logic unused_gen2;
    assign unused_gen2 = m_gen2_mode;

    logic [7:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic       ar_in_ready, aw_in_ready;
    logic       rd_inc, rd_dec, wr_inc, wr_dec;
    ar_word_t   ar_out, aw_out;
    w_word_t    w_out;
    r_word_t    r_in;
    b_word_t    b_in;

    // Limiters gate only link ingress; once a beat is buffered it is always presented.
    assign user_ar_ready = ar_in_ready && (rd_cnt_q < RD_MAX);
    assign user_aw_ready = aw_in_ready && (wr_cnt_q < WR_MAX);

    axi_mm_skid_buf #(.WIDTH(AR_WORD_W)) u_ar_skid (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(user_ar_vld && (rd_cnt_q < RD_MAX)), .in_ready(ar_in_ready),
        .in_data(rxfifo_ar_data),
        .out_valid(user_arvalid), .out_ready(user_arready), .out_data(ar_out)
    );

    axi_mm_skid_buf #(.WIDTH(AR_WORD_W)) u_aw_skid (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(user_aw_vld && (wr_cnt_q < WR_MAX)), .in_ready(aw_in_ready),
        .in_data(rxfifo_aw_data),
        .out_valid(user_awvalid), .out_ready(user_awready), .out_data(aw_out)
    );

    axi_mm_skid_buf #(.WIDTH(W_WORD_W)) u_w_skid (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(user_w_vld), .in_ready(user_w_ready), .in_data(rxfifo_w_data),
        .out_valid(user_wvalid), .out_ready(user_wready), .out_data(w_out)
    );

    assign r_in = '{resp: user_rresp, last: user_rlast, data: user_rdata, id: user_rid};
    assign b_in = '{resp: user_bresp, id: user_bid};

    axi_mm_skid_buf #(.WIDTH(R_WORD_W)) u_r_skid (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(user_rvalid), .in_ready(user_rready), .in_data(r_in),
        .out_valid(user_r_vld), .out_ready(user_r_ready), .out_data(txfifo_r_data)
    );

    axi_mm_skid_buf #(.WIDTH(B_WORD_W)) u_b_skid (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(user_bvalid), .in_ready(user_bready), .in_data(b_in),
        .out_valid(user_b_vld), .out_ready(user_b_ready), .out_data(txfifo_b_data)
    );

    assign user_arid    = ar_out.id;
    assign user_arsize  = ar_out.size;
    assign user_arlen   = ar_out.len;
    assign user_arburst = ar_out.burst;
    assign user_araddr  = ar_out.addr;
    assign user_awid    = aw_out.id;
    assign user_awsize  = aw_out.size;
    assign user_awlen   = aw_out.len;
    assign user_awburst = aw_out.burst;
    assign user_awaddr  = aw_out.addr;
    assign user_wid     = w_out.id;
    assign user_wdata   = w_out.data;
    assign user_wstrb   = w_out.strb;
    assign user_wlast   = w_out.last;

    assign rd_inc = user_ar_vld && user_ar_ready;
    assign rd_dec = user_r_vld && user_r_ready && txfifo_r_data[R_LAST_BIT];
    assign wr_inc = user_aw_vld && user_aw_ready;
    assign wr_dec = user_b_vld && user_b_ready;

    // Simultaneous inc/dec cancels; a stray decrement at zero is ignored.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_inc && !rd_dec)                        rd_cnt_d = rd_cnt_q + 8'd1;
        else if (rd_dec && !rd_inc && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 8'd1;
        if (wr_inc && !wr_dec)                        wr_cnt_d = wr_cnt_q + 8'd1;
        else if (wr_dec && !wr_inc && wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - 8'd1;
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_outstanding = rd_cnt_q;
    assign wr_outstanding = wr_cnt_q;

`ifdef AXI_MM_SLAVE_PROTOCOL_CHECK_EN
    logic [1:0] err_q, err_d;

    assign err_d = err_q | {wr_dec && (wr_cnt_q == '0), rd_dec && (rd_cnt_q == '0)};

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) err_q <= '0;
        else           err_q <= err_d;
    end

    assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_axi_mm_slave_name.sv
// Directed bench for axi_mm_slave_name: table-driven field/latency vectors plus
// hand-written limiter, W-stall, simultaneous-count and reset sequences.
module tb_axi_mm_slave_name;

    logic        clk_wr = 1'b0;
    logic        rst_wr_n;
    logic        user_ar_vld, user_ar_ready, user_aw_vld, user_aw_ready;
    logic [48:0] rxfifo_ar_data, rxfifo_aw_data;
    logic        user_w_vld, user_w_ready;
    logic [76:0] rxfifo_w_data;
    logic        user_r_vld, user_r_ready, user_b_vld, user_b_ready;
    logic [70:0] txfifo_r_data;
    logic [5:0]  txfifo_b_data;
    logic [3:0]  user_arid, user_awid, user_wid, user_rid, user_bid;
    logic [2:0]  user_arsize, user_awsize;
    logic [7:0]  user_arlen, user_awlen, user_wstrb;
    logic [1:0]  user_arburst, user_awburst, user_rresp, user_bresp;
    logic [31:0] user_araddr, user_awaddr;
    logic        user_arvalid, user_arready, user_awvalid, user_awready;
    logic [63:0] user_wdata, user_rdata;
    logic        user_wlast, user_wvalid, user_wready;
    logic        user_rlast, user_rvalid, user_rready, user_bvalid, user_bready;
    logic [7:0]  rd_outstanding, wr_outstanding;
    logic        m_gen2_mode;
`ifdef AXI_MM_SLAVE_PROTOCOL_CHECK_EN
    logic [1:0]  err_sticky;
`endif

    int n_chk = 0;
    int n_fail = 0;

    axi_mm_slave_name dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .user_ar_vld(user_ar_vld), .rxfifo_ar_data(rxfifo_ar_data), .user_ar_ready(user_ar_ready),
        .user_aw_vld(user_aw_vld), .rxfifo_aw_data(rxfifo_aw_data), .user_aw_ready(user_aw_ready),
        .user_w_vld(user_w_vld), .rxfifo_w_data(rxfifo_w_data), .user_w_ready(user_w_ready),
        .user_r_vld(user_r_vld), .txfifo_r_data(txfifo_r_data), .user_r_ready(user_r_ready),
        .user_b_vld(user_b_vld), .txfifo_b_data(txfifo_b_data), .user_b_ready(user_b_ready),
        .user_arid(user_arid), .user_arsize(user_arsize), .user_arlen(user_arlen),
        .user_arburst(user_arburst), .user_araddr(user_araddr),
        .user_arvalid(user_arvalid), .user_arready(user_arready),
        .user_awid(user_awid), .user_awsize(user_awsize), .user_awlen(user_awlen),
        .user_awburst(user_awburst), .user_awaddr(user_awaddr),
        .user_awvalid(user_awvalid), .user_awready(user_awready),
        .user_wid(user_wid), .user_wdata(user_wdata), .user_wstrb(user_wstrb),
        .user_wlast(user_wlast), .user_wvalid(user_wvalid), .user_wready(user_wready),
        .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast),
        .user_rresp(user_rresp), .user_rvalid(user_rvalid), .user_rready(user_rready),
        .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid),
        .user_bready(user_bready),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .m_gen2_mode(m_gen2_mode)
`ifdef AXI_MM_SLAVE_PROTOCOL_CHECK_EN
        , .err_sticky(err_sticky)
`endif
    );

    always #5 clk_wr = ~clk_wr;

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [76:0] wword(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {kk[1:0] == 2'd3, 8'(kk * 3), 32'hC0DE_0000, kk, kk[3:0]};
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [3:0]  id;
        logic [7:0]  exp_cnt;
    } ar_vec_t;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [7:0]  exp_cnt;
    } r_vec_t;

    ar_vec_t ar_tab[3];
    r_vec_t  r_tab[10];

    initial begin
        ar_tab[0] = '{32'h0000_1000, 2'd1, 8'd7,   3'd3, 4'd3,  8'd1};
        ar_tab[1] = '{32'hFFFF_FFFC, 2'd2, 8'hFF,  3'd0, 4'hF,  8'd2};
        ar_tab[2] = '{32'h8000_0001, 2'd0, 8'd0,   3'd5, 4'hA,  8'd3};
        for (int i = 0; i < 8; i++)
            r_tab[i] = '{4'd3, 64'h1111_0000_0000_0000 + 64'(i), (i == 7), 2'd0, 8'd3};
        r_tab[8] = '{4'hF, 64'hDEAD_BEEF_0123_4567, 1'b1, 2'd2, 8'd2};
        r_tab[9] = '{4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd3, 8'd1};

        rst_wr_n = 1'b0;
        user_ar_vld = 0; rxfifo_ar_data = '0; user_aw_vld = 0; rxfifo_aw_data = '0;
        user_w_vld = 0; rxfifo_w_data = '0; user_r_ready = 1; user_b_ready = 1;
        user_arready = 1; user_awready = 1; user_wready = 1;
        user_rid = 0; user_rdata = 0; user_rlast = 0; user_rresp = 0; user_rvalid = 0;
        user_bid = 0; user_bresp = 0; user_bvalid = 0; m_gen2_mode = 0;

        // reset state
        tick(); tick();
        chk("rst_arvalid", user_arvalid, 0);
        chk("rst_r_vld", user_r_vld, 0);
        chk("rst_rd_cnt", rd_outstanding, 0);
        chk("rst_araddr", user_araddr, 0);
        @(negedge clk_wr); rst_wr_n = 1'b1;
        tick();
        chk("rst_ar_ready", user_ar_ready, 1);
        chk("rst_aw_ready", user_aw_ready, 1);
        chk("rst_w_ready", user_w_ready, 1);
        chk("rst_rready", user_rready, 1);
        chk("rst_bready", user_bready, 1);

        // AR field mapping, back-to-back, one-cycle latency
        for (int i = 0; i < 3; i++) begin
            user_ar_vld = 1;
            rxfifo_ar_data = {ar_tab[i].addr, ar_tab[i].burst, ar_tab[i].len,
                              ar_tab[i].size, ar_tab[i].id};
            tick();
            chk("ar_valid", user_arvalid, 1);
            chk("ar_addr", user_araddr, ar_tab[i].addr);
            chk("ar_burst", user_arburst, ar_tab[i].burst);
            chk("ar_len", user_arlen, ar_tab[i].len);
            chk("ar_size", user_arsize, ar_tab[i].size);
            chk("ar_id", user_arid, ar_tab[i].id);
            chk("ar_cnt", rd_outstanding, ar_tab[i].exp_cnt);
        end
        user_ar_vld = 0;
        tick();
        chk("ar_drained", user_arvalid, 0);

        // R packing: 8-beat burst then two single beats; last beats drain rd count
        for (int i = 0; i < 10; i++) begin
            user_rvalid = 1; user_rid = r_tab[i].id; user_rdata = r_tab[i].data;
            user_rlast = r_tab[i].last; user_rresp = r_tab[i].resp;
            tick();
            chk("r_vld", user_r_vld, 1);
            chk("r_word", txfifo_r_data,
                {r_tab[i].resp, r_tab[i].last, r_tab[i].data, r_tab[i].id});
            chk("r_cnt", rd_outstanding, r_tab[i].exp_cnt);
            chk("r_rready", user_rready, 1);
        end
        user_rvalid = 0; user_rlast = 0;
        tick();
        chk("r_cnt_final", rd_outstanding, 0);
        chk("r_vld_idle", user_r_vld, 0);

        // read limiter: 16 ARs close ingress, one R last reopens it
        user_ar_vld = 1; rxfifo_ar_data = {32'h4000, 2'd1, 8'd0, 3'd3, 4'd1};
        for (int i = 0; i < 16; i++) begin
            chk("lim_ready_open", user_ar_ready, 1);
            tick();
        end
        chk("lim_closed", user_ar_ready, 0);
        chk("lim_cnt16", rd_outstanding, 16);
        tick();
        chk("lim_hold16", rd_outstanding, 16);
        user_rvalid = 1; user_rlast = 1;
        tick();
        user_rvalid = 0;
        chk("lim_still_closed", user_ar_ready, 0);
        tick();
        chk("lim_reopen", user_ar_ready, 1);
        chk("lim_cnt15", rd_outstanding, 15);
        user_ar_vld = 0;
        user_rvalid = 1;
        for (int i = 0; i < 15; i++) tick();
        user_rvalid = 0;
        tick();
        chk("lim_drain", rd_outstanding, 0);
        user_rvalid = 1;
        tick();
        user_rvalid = 0;
        tick();
        chk("rd_underflow", rd_outstanding, 0);
`ifdef AXI_MM_SLAVE_PROTOCOL_CHECK_EN
        chk("err_rd", err_sticky, 2'b01);
`endif
        user_rlast = 0;

        // W stream with wready toggling: order, no loss/dup, stable while stalled
        begin
            int sent = 0, recv = 0;
            logic [76:0] prev = '0;
            logic stall = 0, take;
            for (int cyc = 0; cyc < 300 && recv < 32; cyc++) begin
                user_w_vld = (sent < 32);
                rxfifo_w_data = wword(sent);
                user_wready = (cyc % 2 == 0);
                if (stall) chk("w_stable", {user_wlast, user_wstrb, user_wdata, user_wid}, prev);
                if (user_wvalid && user_wready) begin
                    chk("w_beat", {user_wlast, user_wstrb, user_wdata, user_wid}, wword(recv));
                    recv++;
                end
                stall = user_wvalid && !user_wready;
                prev  = {user_wlast, user_wstrb, user_wdata, user_wid};
                take  = user_w_vld && user_w_ready;
                tick();
                if (take) sent++;
            end
            user_w_vld = 0; user_wready = 1;
            chk("w_count", recv, 32);
            tick(); tick();
            chk("w_no_extra", user_wvalid, 0);
        end

        // AW mapping, then AW ingress and B egress in the same cycle
        user_aw_vld = 1; rxfifo_aw_data = {32'h2000_0040, 2'd1, 8'd3, 3'd2, 4'd9};
        tick();
        user_aw_vld = 0;
        chk("aw_valid", user_awvalid, 1);
        chk("aw_fields", {user_awaddr, user_awburst, user_awlen, user_awsize, user_awid},
            {32'h2000_0040, 2'd1, 8'd3, 3'd2, 4'd9});
        chk("aw_cnt1", wr_outstanding, 1);
        user_bvalid = 1; user_bid = 4'd5; user_bresp = 2'd2;
        tick();
        user_bvalid = 0;
        chk("b_vld", user_b_vld, 1);
        chk("b_word", txfifo_b_data, 6'b10_0101);
        user_aw_vld = 1;
        tick();
        user_aw_vld = 0;
        chk("wr_simul", wr_outstanding, 1);
        user_bvalid = 1; tick(); user_bvalid = 0; tick();
        chk("wr_to_zero", wr_outstanding, 0);
`ifdef AXI_MM_SLAVE_PROTOCOL_CHECK_EN
        chk("err_wr_clear", err_sticky[1], 0);
`endif
        user_bvalid = 1; tick(); user_bvalid = 0; tick();
        chk("wr_underflow", wr_outstanding, 0);
`ifdef AXI_MM_SLAVE_PROTOCOL_CHECK_EN
        chk("err_wr", err_sticky[1], 1);
`endif

        // reset with two R beats held in the skid buffer
        user_ar_vld = 1; tick(); user_ar_vld = 0;
        user_r_ready = 0; user_rvalid = 1;
        tick(); tick();
        user_rvalid = 0;
        chk("skid_full", user_rready, 0);
        chk("skid_vld", user_r_vld, 1);
        chk("skid_cnt", rd_outstanding, 1);
        rst_wr_n = 0;
        #2;
        chk("arst_r_vld", user_r_vld, 0);
        chk("arst_cnt", rd_outstanding, 0);
        @(negedge clk_wr); rst_wr_n = 1;
        user_r_ready = 1;
        tick();
        chk("post_rready", user_rready, 1);
        chk("post_r_vld", user_r_vld, 0);
        chk("post_cnts", {rd_outstanding, wr_outstanding}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
